// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch pulse generator: FSM state encoding,
// default counter width and a small config-sanitising helper.
package glitch_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // A repeat count of zero would mean "no pulse", which is never useful; promote it to one.
    function automatic logic [7:0] at_least_one8(input logic [7:0] val);
        return (val == 8'd0) ? 8'd1 : val;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input, followed by a registered
// rising-edge detector producing a one-cycle pulse.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/glitch_pulse_gen.sv
// Armed, trigger-driven glitch pulse generator: after a synchronised trigger
// edge, waits a delay then emits a train of width/gap pulses.
module glitch_pulse_gen
    import glitch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_arm,
    input  logic             i_disarm,
    input  logic             i_trig,
    input  logic [CNT_W-1:0] i_delay,
    input  logic [CNT_W-1:0] i_width,
    input  logic [CNT_W-1:0] i_gap,
    input  logic [7:0]       i_repeat,
    output logic             o_glitch,
    output logic             o_armed,
    output logic             o_firing,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [CNT_W-1:0] r_delay, r_width, r_gap;
    logic [7:0]       r_repeat;
    logic [7:0]       r_left, w_left_next;
    logic             w_done_next;
    logic             w_load;
    logic             w_rise;
    logic             r_glitch, r_armed, r_firing, r_done;

    sync_edge u_trig_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (i_trig),
        .o_rise  (w_rise)
    );

    // Counters load value-1 and terminate at zero, so they never wrap.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_left_next  = r_left;
        w_done_next  = 1'b0;
        w_load       = 1'b0;
        if (i_disarm) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_left_next  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_arm) begin
                        w_state_next = ST_ARMED;
                        w_load       = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_rise) begin
                        w_left_next = r_repeat - 8'd1;
                        if (r_delay != '0) begin
                            w_state_next = ST_DELAY;
                            w_cnt_next   = r_delay - ONE;
                        end else begin
                            w_state_next = ST_PULSE;
                            w_cnt_next   = r_width - ONE;
                        end
                    end
                end
                ST_DELAY, ST_GAP: begin
                    if (r_cnt == '0) begin
                        w_state_next = ST_PULSE;
                        w_cnt_next   = r_width - ONE;
                    end else begin
                        w_cnt_next = r_cnt - ONE;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - ONE;
                    end else if (r_left != 8'd0) begin
                        w_state_next = ST_GAP;
                        w_cnt_next   = r_gap - ONE;
                        w_left_next  = r_left - 8'd1;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                    w_left_next  = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_left   <= '0;
            r_delay  <= '0;
            r_width  <= '0;
            r_gap    <= '0;
            r_repeat <= '0;
            r_glitch <= 1'b0;
            r_armed  <= 1'b0;
            r_firing <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_left   <= w_left_next;
            if (w_load) begin
                r_delay  <= i_delay;
                r_width  <= (i_width == '0) ? ONE : i_width;
                r_gap    <= (i_gap == '0) ? ONE : i_gap;
                r_repeat <= at_least_one8(i_repeat);
            end
            r_glitch <= (w_state_next == ST_PULSE);
            r_armed  <= (w_state_next == ST_ARMED);
            r_firing <= (w_state_next == ST_DELAY) || (w_state_next == ST_PULSE) ||
                        (w_state_next == ST_GAP);
            r_done   <= w_done_next;
        end
    end

    assign o_glitch = r_glitch;
    assign o_armed  = r_armed;
    assign o_firing = r_firing;
    assign o_done   = r_done;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Scoreboard bench for glitch_pulse_gen: per-cycle expected {armed,firing,glitch,done}
// vectors are queued with each stimulus and compared one cycle at a time.
module tb_glitch_pulse_gen;

    localparam int CW = 16;

    localparam logic [3:0] V_IDLE  = 4'b0000;
    localparam logic [3:0] V_ARMED = 4'b1000;
    localparam logic [3:0] V_FIRE  = 4'b0100;
    localparam logic [3:0] V_PULSE = 4'b0110;
    localparam logic [3:0] V_DONE  = 4'b0001;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_arm, i_disarm, i_trig;
    logic [CW-1:0] i_delay, i_width, i_gap;
    logic [7:0]    i_repeat;
    logic          o_glitch, o_armed, o_firing, o_done;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    logic [3:0] exp_q[$];

    glitch_pulse_gen #(.CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_arm    (i_arm),
        .i_disarm (i_disarm),
        .i_trig   (i_trig),
        .i_delay  (i_delay),
        .i_width  (i_width),
        .i_gap    (i_gap),
        .i_repeat (i_repeat),
        .o_glitch (o_glitch),
        .o_armed  (o_armed),
        .o_firing (o_firing),
        .o_done   (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_n(input logic [3:0] v, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(v);
    endtask

    // Advance one edge per queued entry and compare the outputs 1 ns later.
    task automatic run(input string tag, input int n);
        logic [3:0] e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() == 0) begin
                chk_val({tag, "_q_empty"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk_val(tag, {28'd0, o_armed, o_firing, o_glitch, o_done}, {28'd0, e});
            end
        end
    endtask

    task automatic run_all(input string tag);
        run(tag, exp_q.size());
    endtask

    // Arm for one cycle, then scramble the config inputs to prove they were latched.
    task automatic do_arm(input logic [CW-1:0] d, input logic [CW-1:0] w,
                          input logic [CW-1:0] g, input logic [7:0] r, input string tag);
        i_delay = d; i_width = w; i_gap = g; i_repeat = r;
        i_arm = 1'b1;
        push_n(V_ARMED, 1);
        run(tag, 1);
        i_arm = 1'b0;
        i_delay = 16'h0007; i_width = 16'h0009; i_gap = 16'h000b; i_repeat = 8'd5;
    endtask

    // Expected response from the edge that first samples i_trig high (edge 0).
    task automatic push_seq(input int d, input int w, input int g, input int r);
        int wn, gn, rn;
        wn = (w == 0) ? 1 : w;
        gn = (g == 0) ? 1 : g;
        rn = (r == 0) ? 1 : r;
        push_n(V_ARMED, 3);
        push_n(V_FIRE, d);
        for (int p = 0; p < rn; p++) begin
            push_n(V_PULSE, wn);
            if (p < rn - 1) push_n(V_FIRE, gn);
        end
        push_n(V_DONE, 1);
        push_n(V_IDLE, 2);
    endtask

    initial begin
        reset = 1'b1; i_arm = 1'b0; i_disarm = 1'b0; i_trig = 1'b0;
        i_delay = '0; i_width = '0; i_gap = '0; i_repeat = '0;
        push_n(V_IDLE, 3);
        run("reset", 3);
        reset = 1'b0;
        push_n(V_IDLE, 2);
        run("post_reset", 2);

        // delay=5, width=3, repeat=1
        do_arm(16'd5, 16'd3, 16'd0, 8'd1, "a_arm");
        push_n(V_ARMED, 2);
        run("a_wait", 2);
        i_trig = 1'b1;
        push_seq(5, 3, 0, 1);
        run_all("a_seq");
        i_trig = 1'b0;
        push_n(V_IDLE, 3);
        run("a_tail", 3);

        // delay=0, width=1, gap=2, repeat=3
        do_arm(16'd0, 16'd1, 16'd2, 8'd3, "b_arm");
        i_trig = 1'b1;
        push_seq(0, 1, 2, 3);
        run_all("b_seq");
        i_trig = 1'b0;
        push_n(V_IDLE, 3);
        run("b_tail", 3);

        // trigger already high at arm must not fire until it re-rises
        i_trig = 1'b1;
        push_n(V_IDLE, 5);
        run("c_pre", 5);
        do_arm(16'd2, 16'd2, 16'd0, 8'd1, "c_arm");
        push_n(V_ARMED, 6);
        run("c_hold", 6);
        i_trig = 1'b0;
        push_n(V_ARMED, 4);
        run("c_low", 4);
        i_trig = 1'b1;
        push_seq(2, 2, 0, 1);
        run_all("c_seq");
        i_trig = 1'b0;
        push_n(V_IDLE, 3);
        run("c_tail", 3);

        // disarm mid-pulse with width=100
        do_arm(16'd0, 16'd100, 16'd0, 8'd1, "d_arm");
        i_trig = 1'b1;
        push_n(V_ARMED, 3);
        push_n(V_PULSE, 10);
        run_all("d_pulse");
        i_disarm = 1'b1;
        push_n(V_IDLE, 1);
        run("d_disarm", 1);
        i_disarm = 1'b0;
        i_trig = 1'b0;
        push_n(V_IDLE, 4);
        run("d_after", 4);
        i_trig = 1'b1;
        push_n(V_IDLE, 12);
        run("d_retrig", 12);
        i_trig = 1'b0;
        push_n(V_IDLE, 3);
        run("d_tail", 3);

        // reset during GAP of a repeat=4 sequence
        do_arm(16'd0, 16'd2, 16'd3, 8'd4, "e_arm");
        i_trig = 1'b1;
        push_n(V_ARMED, 3);
        push_n(V_PULSE, 2);
        push_n(V_FIRE, 1);
        run_all("e_run");
        reset = 1'b1;
        push_n(V_IDLE, 1);
        run("e_reset", 1);
        reset = 1'b0;
        i_trig = 1'b0;
        push_n(V_IDLE, 4);
        run("e_after", 4);
        i_trig = 1'b1;
        push_n(V_IDLE, 12);
        run("e_retrig", 12);
        i_trig = 1'b0;
        push_n(V_IDLE, 3);
        run("e_tail", 3);

        // zero width/repeat promoted to 1, maximum delay
        do_arm(16'hFFFF, 16'd0, 16'd0, 8'd0, "f_arm");
        i_trig = 1'b1;
        push_seq(65535, 0, 0, 0);
        run_all("f_seq");
        i_trig = 1'b0;

        // arm and disarm together: disarm wins
        i_arm = 1'b1; i_disarm = 1'b1;
        push_n(V_IDLE, 1);
        run("g_both", 1);
        i_arm = 1'b0; i_disarm = 1'b0;
        push_n(V_IDLE, 3);
        run("g_after", 3);

        chk_val("q_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/glitch_pulse_gen.md
GLITCH_PULSE_GEN -- requirements
Module: glitch_pulse_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, setting the width of the delay, width and gap counters.
REQ-002 The block SHALL have port clk, input, 1: the single clock, the 100 MHz sysclk domain; all logic is synchronous to it.
REQ-003 The block SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 The block SHALL have port i_arm, input, 1: one-cycle strobe that latches the configuration and arms the block.
REQ-005 The block SHALL have port i_disarm, input, 1: one-cycle strobe that aborts any activity.
REQ-006 The block SHALL have port i_trig, input, 1: external trigger, asynchronous to clk.
REQ-007 The block SHALL have port i_delay, input, CNT_W: cycles from trigger detect to the first pulse.
REQ-008 The block SHALL have port i_width, input, CNT_W: pulse high time in cycles.
REQ-009 The block SHALL have port i_gap, input, CNT_W: low time between repeated pulses in cycles.
REQ-010 The block SHALL have port i_repeat, input, 8: number of pulses per trigger.
REQ-011 The block SHALL have port o_glitch, output, 1: registered glitch pulse, fed to the output mux.
REQ-012 The block SHALL have port o_armed, output, 1: high in ARMED (waiting-for-trigger LED).
REQ-013 The block SHALL have port o_firing, output, 1: high in DELAY, PULSE or GAP (firing LED).
REQ-014 The block SHALL have port o_done, output, 1: one-cycle strobe when the sequence completes.

Function
REQ-015 The block SHALL implement the states IDLE, ARMED, DELAY, PULSE and GAP; all outputs are registered.
REQ-016 In IDLE, the block SHALL move to ARMED on i_arm and latch i_delay, i_width, i_gap and i_repeat; later input changes have no effect until the next arm.
REQ-017 A latched width, gap or repeat value of 0 SHALL be treated as 1; delay 0 is legal.
REQ-018 The block SHALL pass i_trig through a 2-flop synchroniser followed by a rising-edge detect; a trigger already high at arm SHALL NOT fire until it falls and rises again.
REQ-019 In ARMED, a detected rising edge SHALL move the block to DELAY if delay > 0, else directly to PULSE.
REQ-020 Latency: with edge 0 being the first clk edge that samples i_trig high, o_glitch SHALL rise after edge 3+delay and stay high exactly width cycles.
REQ-021 The block SHALL stay in DELAY for exactly delay cycles, then enter PULSE.
REQ-022 After PULSE, if pulses remain the block SHALL enter GAP for exactly gap cycles (o_glitch low), then PULSE again.
REQ-023 After the last pulse the block SHALL return to IDLE with o_done high for one cycle (single-shot; re-arm required).
REQ-024 i_arm SHALL be ignored outside IDLE.
REQ-025 Trigger edges SHALL be ignored outside ARMED.
REQ-026 i_disarm in any state SHALL force IDLE on the next edge: o_glitch low, counters cleared, no o_done.
REQ-027 When i_arm and i_disarm coincide, disarm SHALL win.
REQ-028 Down-counters SHALL be CNT_W wide and load value-1; they SHALL never wrap, since terminal count is detected at 0.

Reset
REQ-029 On reset, the block SHALL go to IDLE with o_glitch=0, o_armed=0, o_firing=0, o_done=0, synchroniser flops 0, and latched config and counters 0.
REQ-030 Reset mid-pulse SHALL drop o_glitch on the same edge; after reset the block SHALL require a fresh i_arm.

Structure
REQ-031 Package glitch_pkg SHALL hold the state enum and the CNT_W default.
REQ-032 Sub-module sync_edge (2-flop synchroniser plus rising-edge pulse) SHALL be used for i_trig.

Verification
REQ-033 Arm with delay=5, width=3, repeat=1, then raise i_trig: o_glitch high after edges 8,9,10, low after 11; o_done pulses once; o_armed drops at the edge.
REQ-034 delay=0, width=1, gap=2, repeat=3: pulse pattern 1,0,0,1,0,0,1 starting after edge 3; o_done after the third pulse.
REQ-035 i_trig held high before i_arm: no fire; drop and re-raise i_trig: fires with nominal latency.
REQ-036 i_disarm during PULSE with width=100: o_glitch low on the next edge, state IDLE, no o_done; a second trigger causes no output.
REQ-037 Reset asserted during GAP of a repeat=4 sequence: all outputs 0 the next cycle; a trigger without re-arm gives no pulse.
REQ-038 width=0, repeat=0, delay=0xFFFF_FFFF (truncated in simulation to CNT_W=16, delay=0xFFFF): exactly one 1-cycle pulse at the computed latency; i_arm and i_disarm in the same cycle leave the block in IDLE.
